// File: rtl/fetch_queue_if.sv
// fetch_queue_if: groups the fetch stage's bus signals into one bundle.
//   redirect / redirect_pc       : flush-and-refetch request from execute
//   imem_req / imem_addr         : synchronous-read instruction memory request
//   imem_rdata                   : instruction word, valid the cycle after a request
//   instr_valid / instr_ready    : handshake toward decode
//   instr / instr_pc / instr_pc4 : head entry payload (all 0 when not valid)
// Modports: master = the fetch stage, slave = its environment (execute,
// instruction memory and decode seen as one).
interface fetch_queue_if #(
    parameter int n = 32
);
    logic         redirect;
    logic [n-1:0] redirect_pc;
    logic         imem_req;
    logic [n-1:0] imem_addr;
    logic [n-1:0] imem_rdata;
    logic         instr_valid;
    logic         instr_ready;
    logic [n-1:0] instr;
    logic [n-1:0] instr_pc;
    logic [n-1:0] instr_pc4;

    modport master (
        input  redirect, redirect_pc, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc4
    );

    modport slave (
        output redirect, redirect_pc, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc4
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage with a DEPTH-entry prefetch queue.
// Issues sequential (+4) requests to a synchronous-read instruction memory,
// buffers each returned word with its PC, and presents the oldest entry to
// decode. A redirect flushes the queue and any in-flight response and
// restarts fetching at redirect_pc.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; restarts fetching at RESET_PC
//   bus   : fetch_queue_if.master (memory request/response, redirect, decode handshake)
// Parameters:
//   n        : data/address width
//   DEPTH    : queue entries (>= 2; >= 3 sustains one instruction per cycle)
//   RESET_PC : first fetch address after reset
module fetch_queue #(
    parameter int           n        = 32,
    parameter int           DEPTH    = 4,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           reset,
    fetch_queue_if.master bus
);
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [n-1:0]  q_instr [DEPTH];
    logic [n-1:0]  q_pc    [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [n-1:0]  fetch_pc;
    logic [n-1:0]  inflight_pc;
    logic          inflight;

    logic          issue;
    logic          push;
    logic          pop;
    logic          valid;
    logic [OW-1:0] occupancy;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Credit check: a slot is reserved for every request in flight, so a push
    // can never find the queue full. Only the registered count is used, so a
    // pop this cycle frees its slot for issue only from the next cycle.
    assign occupancy = {1'b0, count} + OW'(inflight);
    assign issue     = !reset && !bus.redirect && (occupancy < OW'(DEPTH));

    // A response from last cycle's request is dropped if a redirect (or reset)
    // lands in the cycle it returns.
    assign push = inflight && !bus.redirect && !reset;

    // Decode handshake: the head transfers on a cycle where instr_valid and
    // instr_ready are both 1. instr_valid does not wait on instr_ready. It is
    // forced low during redirect and reset, which voids any handshake then.
    assign valid = !reset && !bus.redirect && (count != '0);
    assign pop   = valid && bus.instr_ready;

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr_valid = valid;
    assign bus.instr       = valid ? q_instr[head] : '0;
    assign bus.instr_pc    = valid ? q_pc[head] : '0;
    assign bus.instr_pc4   = valid ? (q_pc[head] + n'(4)) : '0;

    // Queue storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[tail] <= bus.imem_rdata;
            q_pc[tail]    <= inflight_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            if (push) begin
                tail <= wrap_inc(tail);
            end
            if (pop) begin
                head <= wrap_inc(head);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + n'(4);
            end
        end
    end
endmodule
